// File: rtl/control_pd_debug_capture_multi_if.sv
// PD bus, match/capture configuration and readback signals for the multi-field PD debug capture block.
// The master drives the datapath PD and configuration inputs; the slave (the capture block) returns counters, status and read data.
interface control_pd_debug_capture_multi_if #(
    parameter int PD_WIDTH          = 100,
    parameter int NUM_FIELDS        = 4,
    parameter int DEPTH             = 4,
    parameter int PACKET_SIZE_WIDTH = 12
);
    localparam int NUM_WORDS = (PD_WIDTH + 31) / 32;
    localparam int EW        = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int WSW       = $clog2(NUM_WORDS + 1);

    logic                             e_valid;
    logic [PD_WIDTH-1:0]              eq_pd;
    logic [NUM_FIELDS*PD_WIDTH-1:0]   cfg_value;
    logic [NUM_FIELDS*PD_WIDTH-1:0]   cfg_mask;
    logic                             cfg_en;
    logic                             cfg_capture_en;
    logic [NUM_FIELDS-1:0]            cfg_capture_field_sel;
    logic                             cfg_trig_en;
    logic                             cfg_ring_mode;
    logic                             capture_trigger;
    logic                             arm;
    logic                             stop;
    logic [EW-1:0]                    rd_entry_sel;
    logic [WSW-1:0]                   rd_word_sel;

    logic [NUM_FIELDS-1:0]            field_cnt_inc;
    logic [NUM_FIELDS-1:0]            field_byte_cnt_inc;
    logic [PACKET_SIZE_WIDTH-1:0]     byte_cnt_inc_amount;
    logic                             total_pd_cnt_inc;
    logic                             trigger_cnt_inc;
    logic                             capture_match_o;
    logic [1:0]                       capture_state;
    logic [CW-1:0]                    capture_count;
    logic                             capture_wrapped;
    logic [31:0]                      dbg_out;

    modport master (
        output e_valid, eq_pd, cfg_value, cfg_mask, cfg_en, cfg_capture_en,
               cfg_capture_field_sel, cfg_trig_en, cfg_ring_mode, capture_trigger,
               arm, stop, rd_entry_sel, rd_word_sel,
        input  field_cnt_inc, field_byte_cnt_inc, byte_cnt_inc_amount, total_pd_cnt_inc,
               trigger_cnt_inc, capture_match_o, capture_state, capture_count,
               capture_wrapped, dbg_out
    );

    modport slave (
        input  e_valid, eq_pd, cfg_value, cfg_mask, cfg_en, cfg_capture_en,
               cfg_capture_field_sel, cfg_trig_en, cfg_ring_mode, capture_trigger,
               arm, stop, rd_entry_sel, rd_word_sel,
        output field_cnt_inc, field_byte_cnt_inc, byte_cnt_inc_amount, total_pd_cnt_inc,
               trigger_cnt_inc, capture_match_o, capture_state, capture_count,
               capture_wrapped, dbg_out
    );
endinterface

// File: rtl/control_pd_debug_capture_multi.sv
// Multi-field PD matcher with DEPTH-entry capture history; counters are combinational, captures land one edge after the PD, dbg_out one edge after its select.
// No backpressure: the PD bus is observed passively and never stalled.
module control_pd_debug_capture_multi #(
    parameter int PD_WIDTH           = 100,
    parameter int NUM_FIELDS         = 4,
    parameter int DEPTH              = 4,
    parameter int PACKET_SIZE_OFFSET = 0,
    parameter int PACKET_SIZE_WIDTH  = 12
) (
    input  logic                           clk,
    input  logic                           rstn,
    control_pd_debug_capture_multi_if.slave bus
);
    localparam int NUM_WORDS = (PD_WIDTH + 31) / 32;
    localparam int EW        = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int WSW       = $clog2(NUM_WORDS + 1);
    localparam int PADW      = NUM_WORDS * 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [EW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wrapped_q, wrapped_d;
    logic [31:0]           dbg_q, dbg_d;

    logic [PD_WIDTH-1:0]   pd_mem  [DEPTH];
    logic [NUM_FIELDS-1:0] hit_mem [DEPTH];

    logic [NUM_FIELDS-1:0] hit;
    logic                  qual;
    logic                  wr;
    logic [EW-1:0]         rd_phys;
    logic                  rd_valid;
    logic [PADW-1:0]       rd_pad;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            hit[i] = bus.e_valid &
                     ((bus.eq_pd & bus.cfg_mask[i*PD_WIDTH +: PD_WIDTH]) ==
                      (bus.cfg_value[i*PD_WIDTH +: PD_WIDTH] & bus.cfg_mask[i*PD_WIDTH +: PD_WIDTH]));
        end
    end

    assign qual = bus.cfg_en & ((|(hit & bus.cfg_capture_field_sel)) |
                                (bus.e_valid & bus.capture_trigger & bus.cfg_trig_en));
    // A restart, a disable or a reset in the same cycle drops the PD rather than writing it.
    assign wr   = qual & rstn & bus.cfg_capture_en & ~bus.arm & (state_q == ST_ARMED);

    assign bus.field_cnt_inc       = hit & {NUM_FIELDS{bus.cfg_en}};
    assign bus.field_byte_cnt_inc  = hit & {NUM_FIELDS{bus.cfg_en}};
    assign bus.byte_cnt_inc_amount = bus.eq_pd[PACKET_SIZE_OFFSET +: PACKET_SIZE_WIDTH];
    assign bus.total_pd_cnt_inc    = bus.e_valid & bus.cfg_en;
    assign bus.trigger_cnt_inc     = bus.e_valid & bus.capture_trigger & bus.cfg_trig_en & bus.cfg_en;
    assign bus.capture_match_o     = wr;
    assign bus.capture_state       = state_q;
    assign bus.capture_count       = count_q;
    assign bus.capture_wrapped     = wrapped_q;
    assign bus.dbg_out             = dbg_q;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (!bus.cfg_capture_en) begin
            state_d = ST_IDLE;
        end else if (bus.arm) begin
            state_d   = ST_ARMED;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
        end else if (state_q == ST_ARMED) begin
            if (wr) begin
                wr_ptr_d = wr_ptr_q + EW'(1);
                if (count_q == CW'(DEPTH)) begin
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
                if (!bus.cfg_ring_mode && (count_q == CW'(DEPTH - 1))) begin
                    state_d = ST_DONE;
                end
            end
            if (bus.stop) begin
                state_d = ST_DONE;
            end
        end
    end

    // Once wrapped, wr_ptr points at the oldest surviving entry.
    always_comb begin
        rd_phys  = (wrapped_q ? wr_ptr_q : '0) + bus.rd_entry_sel;
        rd_valid = CW'(bus.rd_entry_sel) < count_q;
        rd_pad   = PADW'(pd_mem[rd_phys]);
        dbg_d    = '0;
        if (rd_valid) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (bus.rd_word_sel == WSW'(w)) begin
                    dbg_d = rd_pad[w*32 +: 32];
                end
            end
            if (bus.rd_word_sel == WSW'(NUM_WORDS)) begin
                dbg_d = {1'b1, 15'b0, 16'(hit_mem[rd_phys])};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            dbg_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            dbg_q     <= dbg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pd_mem[wr_ptr_q]  <= bus.eq_pd;
            hit_mem[wr_ptr_q] <= hit;
        end
    end
endmodule

// File: tb/tb_control_pd_debug_capture_multi.sv
// Bench for the multi-field PD debug capture block: vector table, directed capture sessions, then random traffic against a queue-based model.
module tb_control_pd_debug_capture_multi;
    logic clk;
    logic rstn;
    int   n_chk;
    int   n_err;

    control_pd_debug_capture_multi_if #(.PD_WIDTH(100), .NUM_FIELDS(4), .DEPTH(4), .PACKET_SIZE_WIDTH(12)) bus ();

    control_pd_debug_capture_multi #(
        .PD_WIDTH(100), .NUM_FIELDS(4), .DEPTH(4), .PACKET_SIZE_OFFSET(0), .PACKET_SIZE_WIDTH(12)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [99:0] pd;
        logic [3:0]  hit;
    } ent_t;

    typedef struct {
        logic        vld;
        logic [99:0] pd;
        logic        en;
        logic        trig;
        logic        trig_en;
        logic [3:0]  exp_f;
        logic [11:0] exp_b;
        logic        exp_tot;
        logic        exp_trg;
    } vec_t;

    logic [99:0] cfg_val [4];
    logic [99:0] cfg_msk [4];
    ent_t        m_q[$];
    int          m_state;
    logic        m_wrapped;
    logic [31:0] exp_dbg;
    vec_t        vt [7];
    logic [99:0] b99;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_hits();
        logic [3:0] h;
        h = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.e_valid && (((bus.eq_pd ^ cfg_val[i]) & cfg_msk[i]) == '0)) h[i] = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [31:0] m_read(input int e, input int w);
        logic [127:0] pad;
        if (e >= m_q.size()) return 32'h0;
        if (w < 4) begin
            pad = {28'b0, m_q[e].pd};
            return pad[w*32 +: 32];
        end
        if (w == 4) return {1'b1, 15'b0, 12'b0, m_q[e].hit};
        return 32'h0;
    endfunction

    // One clock: check everything at the falling edge, then advance the model across the rising edge.
    task automatic step();
        logic [3:0] h;
        logic       wr;
        int         sz;
        @(negedge clk);
        h  = m_hits();
        wr = rstn && bus.cfg_capture_en && !bus.arm && (m_state == 1) && bus.cfg_en &&
             ((|(h & bus.cfg_capture_field_sel)) || (bus.e_valid && bus.capture_trigger && bus.cfg_trig_en));
        chk("field_cnt_inc",      128'(bus.field_cnt_inc),       128'(bus.cfg_en ? h : 4'h0));
        chk("field_byte_cnt_inc", 128'(bus.field_byte_cnt_inc),  128'(bus.cfg_en ? h : 4'h0));
        chk("byte_amount",        128'(bus.byte_cnt_inc_amount), 128'(bus.eq_pd[11:0]));
        chk("total_pd_cnt_inc",   128'(bus.total_pd_cnt_inc),    128'(bus.e_valid && bus.cfg_en));
        chk("trigger_cnt_inc",    128'(bus.trigger_cnt_inc),
            128'(bus.e_valid && bus.capture_trigger && bus.cfg_trig_en && bus.cfg_en));
        chk("capture_match",      128'(bus.capture_match_o),     128'(wr));
        chk("capture_state",      128'(bus.capture_state),       128'(m_state));
        chk("capture_count",      128'(bus.capture_count),       128'(m_q.size()));
        chk("capture_wrapped",    128'(bus.capture_wrapped),     128'(m_wrapped));
        chk("dbg_out",            128'(bus.dbg_out),             128'(exp_dbg));
        exp_dbg = m_read(int'(bus.rd_entry_sel), int'(bus.rd_word_sel));
        if (!rstn) begin
            m_state = 0; m_q.delete(); m_wrapped = 1'b0; exp_dbg = 32'h0;
        end else if (!bus.cfg_capture_en) begin
            m_state = 0;
        end else if (bus.arm) begin
            m_state = 1; m_q.delete(); m_wrapped = 1'b0;
        end else if (m_state == 1) begin
            if (wr) begin
                sz = m_q.size();
                m_q.push_back('{bus.eq_pd, h});
                if (m_q.size() > 4) begin
                    void'(m_q.pop_front());
                    m_wrapped = 1'b1;
                end
                if (!bus.cfg_ring_mode && sz == 3) m_state = 2;
            end
            if (bus.stop) m_state = 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic a, input logic s);
        bus.e_valid = 1'b0; bus.arm = a; bus.stop = s;
        step();
        bus.arm = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic pd_step(input logic [99:0] pd);
        bus.e_valid = 1'b1; bus.eq_pd = pd;
        step();
        bus.e_valid = 1'b0;
    endtask

    task automatic read_chk(input string nm, input int e, input int w, input logic [31:0] exp);
        bus.rd_entry_sel = 2'(e); bus.rd_word_sel = 3'(w);
        step();
        chk(nm, 128'(bus.dbg_out), 128'(exp));
    endtask

    initial begin
        int tf, tt;
        n_chk = 0; n_err = 0;
        b99 = 100'd1 << 99;
        cfg_msk[0] = 100'hFF;        cfg_val[0] = 100'h12;
        cfg_msk[1] = 100'hF00;       cfg_val[1] = 100'h300;
        cfg_msk[2] = 100'hFFFF_0000; cfg_val[2] = 100'hBEEF_0000;
        cfg_msk[3] = b99;            cfg_val[3] = b99;
        for (int i = 0; i < 4; i++) begin
            bus.cfg_value[i*100 +: 100] = cfg_val[i];
            bus.cfg_mask[i*100 +: 100]  = cfg_msk[i];
        end
        rstn = 1'b0;
        bus.e_valid = 1'b0; bus.eq_pd = '0; bus.cfg_en = 1'b1; bus.cfg_capture_en = 1'b0;
        bus.cfg_capture_field_sel = 4'b0001; bus.cfg_trig_en = 1'b0; bus.cfg_ring_mode = 1'b0;
        bus.capture_trigger = 1'b0; bus.arm = 1'b0; bus.stop = 1'b0;
        bus.rd_entry_sel = '0; bus.rd_word_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",   128'(bus.capture_state),   128'(0));
        chk("rst_count",   128'(bus.capture_count),   128'(0));
        chk("rst_wrapped", 128'(bus.capture_wrapped), 128'(0));
        chk("rst_dbg",     128'(bus.dbg_out),         128'(0));
        m_state = 0; m_wrapped = 1'b0; exp_dbg = 32'h0; m_q.delete();
        rstn = 1'b1;

        vt[0] = '{1'b1, 100'h312,             1'b1, 1'b0, 1'b0, 4'b0011, 12'h312, 1'b1, 1'b0};
        vt[1] = '{1'b0, 100'h312,             1'b1, 1'b0, 1'b0, 4'b0000, 12'h312, 1'b0, 1'b0};
        vt[2] = '{1'b1, 100'h12,              1'b0, 1'b0, 1'b0, 4'b0000, 12'h012, 1'b0, 1'b0};
        vt[3] = '{1'b1, b99 | 100'hBEEF_0400, 1'b1, 1'b0, 1'b0, 4'b1100, 12'h400, 1'b1, 1'b0};
        vt[4] = '{1'b1, 100'h13,              1'b1, 1'b1, 1'b1, 4'b0000, 12'h013, 1'b1, 1'b1};
        vt[5] = '{1'b1, 100'hBEEF_0312,       1'b1, 1'b1, 1'b0, 4'b0111, 12'h312, 1'b1, 1'b0};
        vt[6] = '{1'b1, b99 | 100'h12,        1'b0, 1'b1, 1'b1, 4'b0000, 12'h012, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            bus.e_valid = vt[k].vld; bus.eq_pd = vt[k].pd; bus.cfg_en = vt[k].en;
            bus.capture_trigger = vt[k].trig; bus.cfg_trig_en = vt[k].trig_en;
            #2;
            chk("vec_field",   128'(bus.field_cnt_inc),       128'(vt[k].exp_f));
            chk("vec_fbyte",   128'(bus.field_byte_cnt_inc),  128'(vt[k].exp_f));
            chk("vec_bytes",   128'(bus.byte_cnt_inc_amount), 128'(vt[k].exp_b));
            chk("vec_total",   128'(bus.total_pd_cnt_inc),    128'(vt[k].exp_tot));
            chk("vec_trigger", 128'(bus.trigger_cnt_inc),     128'(vt[k].exp_trg));
        end
        bus.e_valid = 1'b0; bus.cfg_en = 1'b1; bus.capture_trigger = 1'b0; bus.cfg_trig_en = 1'b0;
        @(posedge clk);
        #1;

        tf = 0; tt = 0;
        for (int k = 0; k < 3; k++) begin
            bus.e_valid = 1'b1; bus.eq_pd = (100'(k + 5) << 12) | 100'h812;
            #1;
            tf += int'(bus.field_cnt_inc[0]);
            tt += int'(bus.total_pd_cnt_inc);
            step();
        end
        bus.e_valid = 1'b0;
        chk("pulse_field0", 128'(tf), 128'(3));
        chk("pulse_total",  128'(tt), 128'(3));

        bus.cfg_capture_en = 1'b1; bus.cfg_ring_mode = 1'b0;
        pulse(1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            pd_step((100'(k) << 16) | 100'h12);
            if (k == 4) chk("full_state_after_d", 128'(bus.capture_state), 128'(2));
        end
        chk("full_count", 128'(bus.capture_count), 128'(4));
        for (int e = 0; e < 4; e++) read_chk("full_entry", e, 0, (32'(e + 1) << 16) | 32'h12);

        bus.cfg_ring_mode = 1'b1;
        pulse(1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) pd_step((100'(k) << 16) | 100'h12);
        pulse(1'b0, 1'b1);
        chk("ring_wrapped", 128'(bus.capture_wrapped), 128'(1));
        chk("ring_count",   128'(bus.capture_count),   128'(4));
        chk("ring_state",   128'(bus.capture_state),   128'(2));
        for (int e = 0; e < 4; e++) read_chk("ring_entry", e, 0, (32'(e + 3) << 16) | 32'h12);

        bus.cfg_ring_mode = 1'b0;
        pulse(1'b1, 1'b0);
        pd_step(100'h312);
        read_chk("meta_two_fields", 0, 4, 32'h8000_0003);
        read_chk("read_past_count", 2, 0, 32'h0);
        read_chk("word_past_meta",  0, 5, 32'h0);

        pulse(1'b1, 1'b0);
        bus.stop = 1'b1;
        pd_step(100'h12);
        bus.stop = 1'b0;
        chk("wr_stop_state", 128'(bus.capture_state), 128'(2));
        chk("wr_stop_count", 128'(bus.capture_count), 128'(1));
        pulse(1'b1, 1'b0);
        pd_step(100'h12);
        pd_step(100'h12);
        bus.arm = 1'b1;
        pd_step(100'h12);
        bus.arm = 1'b0;
        chk("wr_arm_count", 128'(bus.capture_count), 128'(0));
        chk("wr_arm_state", 128'(bus.capture_state), 128'(1));

        pd_step(100'h12);
        pd_step(100'h12);
        bus.cfg_capture_en = 1'b0;
        step();
        chk("dis_state", 128'(bus.capture_state), 128'(0));
        chk("dis_count", 128'(bus.capture_count), 128'(2));
        bus.cfg_capture_en = 1'b1;
        pulse(1'b1, 1'b0);
        pd_step(100'h12);
        read_chk("pre_rst_meta", 0, 4, 32'h8000_0001);
        rstn = 1'b0;
        step();
        chk("midrst_state",   128'(bus.capture_state),   128'(0));
        chk("midrst_count",   128'(bus.capture_count),   128'(0));
        chk("midrst_wrapped", 128'(bus.capture_wrapped), 128'(0));
        chk("midrst_dbg",     128'(bus.dbg_out),         128'(0));
        rstn = 1'b1;

        for (int c = 0; c < 2000; c++) begin
            int r;
            rstn                      = ($urandom_range(0, 299) != 0);
            bus.cfg_en                = ($urandom_range(0, 15) != 0);
            bus.cfg_capture_en        = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 199) == 0) bus.cfg_ring_mode = ~bus.cfg_ring_mode;
            bus.arm                   = ($urandom_range(0, 19) == 0);
            bus.stop                  = ($urandom_range(0, 24) == 0);
            bus.e_valid               = 1'($urandom_range(0, 1));
            bus.eq_pd                 = 100'({$urandom(), $urandom(), $urandom(), $urandom()});
            r = $urandom_range(0, 3);
            if (r == 0) bus.eq_pd[7:0] = 8'h12;
            if (r == 1) bus.eq_pd[11:8] = 4'h3;
            bus.cfg_capture_field_sel = 4'($urandom());
            bus.capture_trigger       = ($urandom_range(0, 3) == 0);
            bus.cfg_trig_en           = 1'($urandom_range(0, 1));
            bus.rd_entry_sel          = 2'($urandom());
            bus.rd_word_sel           = 3'($urandom());
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/control_pd_debug_capture_multi.md
# control_pd_debug_capture_multi

Multi-field packet-descriptor (PD) debug matcher with a DEPTH-entry capture history buffer. It sits beside a datapath PD bus, like the existing single-capture PD debug block. It extends that block to NUM_FIELDS masked match comparators and an arm/stop capture state machine with stop-when-full and ring modes. Captured PDs are read back through a registered 32-bit word/entry mux for CIF access.

## Interface
- PD_WIDTH, 100: width of eq_pd.
- NUM_FIELDS, 4: number of value/mask comparators; legal range 1..16.
- DEPTH, 4: capture buffer entries; power of two, at least 2.
- PACKET_SIZE_OFFSET, 0: LSB of the byte-count field in the PD.
- PACKET_SIZE_WIDTH, 12: width of the byte-count field.
- NUM_WORDS, ceil(PD_WIDTH/32): derived; number of 32-bit PD words.
- clk  in  1  single clock; all state on posedge.
- rstn  in  1  reset; synchronous, active-low.
- e_valid  in  1  PD valid.
- eq_pd  in  PD_WIDTH  PD data.
- cfg_value  in  NUM_FIELDS*PD_WIDTH  match values; field i occupies [i*PD_WIDTH +: PD_WIDTH].
- cfg_mask  in  NUM_FIELDS*PD_WIDTH  match masks, packed the same way.
- cfg_en  in  1  enables the counter-increment outputs.
- cfg_capture_en  in  1  enables capture; while low, state is forced to IDLE.
- cfg_capture_field_sel  in  NUM_FIELDS  fields that qualify a capture.
- cfg_trig_en  in  1  allows capture_trigger to qualify a capture.
- cfg_ring_mode  in  1  0 = stop-when-full, 1 = ring.
- capture_trigger  in  1  designer-driven capture request.
- arm  in  1  pulse: start a capture session.
- stop  in  1  pulse: end a capture session.
- rd_entry_sel  in  clog2(DEPTH)  read entry index; 0 = oldest.
- rd_word_sel  in  clog2(NUM_WORDS+1)  read word index; index NUM_WORDS selects the metadata word.
- field_cnt_inc  out  NUM_FIELDS  per-field match pulse.
- field_byte_cnt_inc  out  NUM_FIELDS  equal to field_cnt_inc.
- byte_cnt_inc_amount  out  PACKET_SIZE_WIDTH  eq_pd[PACKET_SIZE_OFFSET +: PACKET_SIZE_WIDTH].
- total_pd_cnt_inc  out  1  e_valid & cfg_en.
- trigger_cnt_inc  out  1  e_valid & capture_trigger & cfg_trig_en & cfg_en.
- capture_match_o  out  1  pulse when an entry is written.
- capture_state  out  2  0 = IDLE, 1 = ARMED, 2 = DONE.
- capture_count  out  clog2(DEPTH+1)  number of valid entries.
- capture_wrapped  out  1  ring mode has overwritten at least one entry.
- dbg_out  out  32  read data.

## Operation
- hit[i] = e_valid & ((eq_pd & mask_i) == (value_i & mask_i)).
- field_cnt_inc[i] = hit[i] & cfg_en. These outputs are combinational in the same cycle as e_valid.
- Capture qualifier: qual = cfg_en & (|(hit & cfg_capture_field_sel) | (e_valid & capture_trigger & cfg_trig_en)).
- Write event: wr = qual while state is ARMED. An entry stores eq_pd plus the hit[NUM_FIELDS-1:0] bitmap. capture_match_o = wr.
- FSM transitions:
  - IDLE -> ARMED on arm. Clears wr_ptr, capture_count and capture_wrapped.
  - ARMED -> DONE on stop.
  - ARMED -> DONE in stop-when-full mode when a wr takes capture_count to DEPTH.
  - DONE -> ARMED on arm.
  - arm while already ARMED restarts the session (same clearing as IDLE -> ARMED).
  - cfg_capture_en low: state forced to IDLE next cycle. Buffer contents, count and wrapped are retained.
- Stop-when-full mode: the first DEPTH qualifying PDs are kept. Events after DONE are ignored.
- Ring mode: wr_ptr wraps modulo DEPTH and overwrites the oldest entry. capture_count saturates at DEPTH. capture_wrapped sets on the first overwrite.
- Read mapping:
  - Physical entry = (oldest_ptr + rd_entry_sel) mod DEPTH, where oldest_ptr = wrapped ? wr_ptr : 0.
  - Word w < NUM_WORDS returns PD bits [32w +: 32]; bits above PD_WIDTH read as 0.
  - Word NUM_WORDS returns {valid, 15'b0, 16-bit zero-extended hit bitmap}.
  - Entries with rd_entry_sel >= capture_count, and words above NUM_WORDS, return 0 with valid = 0.
- Simultaneous events:
  - arm with stop: arm wins.
  - wr with stop: the entry is written, then DONE.
  - wr with arm: the restart wins and the PD is not written.

## Timing
- Reset values: capture_state = IDLE, capture_count = 0, capture_wrapped = 0, dbg_out = 0, wr_ptr = 0.
- Buffer storage is not reset. Validity is derived from capture_count only.
- The buffer entry, capture_count, wr_ptr and state update on the edge following the wr cycle.
- dbg_out is registered: a select applied in cycle N appears in cycle N+1.
- Reset asserted mid-session returns to IDLE on that edge, and any in-flight wr is discarded.
- A read of an entry written in cycle N is valid with the select applied in cycle N+1; data appears in cycle N+2.

## Test plan
- Reset, then cfg_en = 1, field0 mask = 0xFF, value = 0x12, 3 PDs with eq_pd[7:0] = 0x12 -> field_cnt_inc[0] pulses 3 times, total_pd_cnt_inc pulses 3 times, byte_cnt_inc_amount = eq_pd[11:0].
- Stop-when-full mode, DEPTH = 4, arm, 6 matching PDs A..F -> capture_count = 4, state DONE after D; entry 0..3 = A..D; E and F are ignored.
- Ring mode, arm, 6 matches A..F, then stop -> entries 0..3 = C..F, capture_wrapped = 1, capture_count = 4.
- Two fields matching the same PD -> metadata word = 0x8000_0003; rd_entry_sel = 2 with capture_count = 1 -> dbg_out = 0.
- wr coincident with stop -> entry written, state DONE. wr coincident with arm -> capture_count = 0 next cycle.
- cfg_capture_en dropped mid-session -> IDLE next cycle with count retained. rstn low mid-session -> all outputs return to their reset values.
